// File: rtl/collector_pkg.sv
// Shared types and helpers for the result_collector gather hub.
package collector_pkg;

    typedef enum logic [1:0] {
        RELEASE = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam int DEFAULT_DATA_W = 32;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/result_collector_if.sv
// Parent/child-facing signal bundle of the result collector.
interface result_collector_if
    import collector_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = DEFAULT_DATA_W,
    parameter int ADDR_W       = addr_width(NUM_CHILDREN)
);
    logic [NUM_CHILDREN-1:0]        child_flag;
    logic [NUM_CHILDREN*DATA_W-1:0] child_val_1;
    logic [NUM_CHILDREN*DATA_W-1:0] child_val_2;
    logic [NUM_CHILDREN-1:0]        child_reset;
    logic                           round_clear;
    logic [ADDR_W-1:0]              rd_addr;
    logic [DATA_W-1:0]              rd_val_1;
    logic [DATA_W-1:0]              rd_val_2;
    logic [NUM_CHILDREN-1:0]        captured;
    logic                           all_done;
    logic [DATA_W-1:0]              min_val;
    logic [ADDR_W-1:0]              min_idx;
    logic [DATA_W-1:0]              min_val_2;

    modport master (
        output child_flag, child_val_1, child_val_2, round_clear, rd_addr,
        input  child_reset, rd_val_1, rd_val_2, captured, all_done,
               min_val, min_idx, min_val_2
    );

    modport slave (
        input  child_flag, child_val_1, child_val_2, round_clear, rd_addr,
        output child_reset, rd_val_1, rd_val_2, captured, all_done,
               min_val, min_idx, min_val_2
    );
endinterface

// File: rtl/reset_stagger.sv
// Releases child resets one per cycle after a one-cycle arm delay, child 0 first.
module reset_stagger #(
    parameter int NUM_CHILDREN = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [NUM_CHILDREN-1:0] child_reset,
    output logic                    release_done
);
    localparam logic [NUM_CHILDREN-1:0] LAST_ONLY = NUM_CHILDREN'(1) << (NUM_CHILDREN - 1);

    logic                    arm_reg;
    logic [NUM_CHILDREN-1:0] reset_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) arm_reg <= 1'b0;
        else        arm_reg <= 1'b1;
    end

    // A zero enters at bit 0 and walks upward, so child i drops one cycle after child i-1.
    for (genvar gi = 0; gi < NUM_CHILDREN; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                reset_reg[gi] <= 1'b1;
            end else if (arm_reg) begin
                if (gi == 0) reset_reg[gi] <= 1'b0;
                else         reset_reg[gi] <= reset_reg[(gi == 0) ? 0 : gi - 1];
            end
        end
    end

    assign child_reset  = reset_reg;
    assign release_done = arm_reg && (reset_reg == LAST_ONLY);
endmodule

// File: rtl/result_collector.sv
// Round-based gather hub: staggered child release, first-edge capture, registered read port.
// Optional running minimum over captured val_1 is built when COLLECTOR_MIN_REDUCE_EN is defined.
module result_collector
    import collector_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int DATA_W       = DEFAULT_DATA_W
) (
    input logic               clk,
    input logic               rst_n,
    result_collector_if.slave bus
);
    localparam int ADDR_W = addr_width(NUM_CHILDREN);

    state_t                  state_reg, state_next;
    logic [NUM_CHILDREN-1:0] flag_prev_reg;
    logic [NUM_CHILDREN-1:0] captured_reg, captured_next;
    logic [NUM_CHILDREN-1:0] rise, cap_en;
    logic [NUM_CHILDREN-1:0] child_reset;
    logic                    release_done;
    logic [DATA_W-1:0]       val_1_in [NUM_CHILDREN];
    logic [DATA_W-1:0]       val_2_in [NUM_CHILDREN];
    logic [DATA_W-1:0]       val_1_mem_reg [NUM_CHILDREN];
    logic [DATA_W-1:0]       val_2_mem_reg [NUM_CHILDREN];
    logic [DATA_W-1:0]       rd_val_1_reg, rd_val_1_next;
    logic [DATA_W-1:0]       rd_val_2_reg, rd_val_2_next;

    reset_stagger #(.NUM_CHILDREN(NUM_CHILDREN)) u_stagger (
        .clk          (clk),
        .rst_n        (rst_n),
        .child_reset  (child_reset),
        .release_done (release_done)
    );

    assign rise = bus.child_flag & ~flag_prev_reg;

    always_comb begin
        state_next    = state_reg;
        captured_next = captured_reg;
        cap_en        = '0;
        case (state_reg)
            RELEASE: if (release_done) state_next = COLLECT;
            COLLECT, DONE: begin
                // A clear opens a new round, and edges arriving with it belong to that round.
                if (bus.round_clear) begin
                    cap_en        = rise;
                    captured_next = rise;
                end else if (state_reg == COLLECT) begin
                    cap_en        = rise & ~captured_reg;
                    captured_next = captured_reg | cap_en;
                end
                if (bus.round_clear || state_reg == COLLECT)
                    state_next = (&captured_next) ? DONE : COLLECT;
            end
            default: state_next = RELEASE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RELEASE;
            flag_prev_reg <= '0;
            captured_reg  <= '0;
            rd_val_1_reg  <= '0;
            rd_val_2_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            flag_prev_reg <= bus.child_flag;
            captured_reg  <= captured_next;
            rd_val_1_reg  <= rd_val_1_next;
            rd_val_2_reg  <= rd_val_2_next;
        end
    end

    for (genvar gi = 0; gi < NUM_CHILDREN; gi++) begin : g_child
        assign val_1_in[gi] = bus.child_val_1[gi*DATA_W +: DATA_W];
        assign val_2_in[gi] = bus.child_val_2[gi*DATA_W +: DATA_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                val_1_mem_reg[gi] <= '0;
                val_2_mem_reg[gi] <= '0;
            end else if (cap_en[gi]) begin
                val_1_mem_reg[gi] <= val_1_in[gi];
                val_2_mem_reg[gi] <= val_2_in[gi];
            end
        end
    end

    // Bypass the incoming pair so a same-edge capture is visible on the read port.
    always_comb begin
        rd_val_1_next = '0;
        rd_val_2_next = '0;
        if (32'(bus.rd_addr) < NUM_CHILDREN) begin
            if (cap_en[bus.rd_addr]) begin
                rd_val_1_next = val_1_in[bus.rd_addr];
                rd_val_2_next = val_2_in[bus.rd_addr];
            end else begin
                rd_val_1_next = val_1_mem_reg[bus.rd_addr];
                rd_val_2_next = val_2_mem_reg[bus.rd_addr];
            end
        end
    end

    assign bus.child_reset = child_reset;
    assign bus.captured    = captured_reg;
    assign bus.all_done    = (state_reg == DONE);
    assign bus.rd_val_1    = rd_val_1_reg;
    assign bus.rd_val_2    = rd_val_2_reg;

`ifdef COLLECTOR_MIN_REDUCE_EN
    logic [DATA_W-1:0] min_val_reg, min_val_next;
    logic [ADDR_W-1:0] min_idx_reg, min_idx_next;
    logic [DATA_W-1:0] min_val_2_reg, min_val_2_next;
    logic              min_valid_reg, min_valid_next;

    // Scan in index order; equal values only displace a higher-indexed holder.
    always_comb begin
        min_val_next   = min_val_reg;
        min_idx_next   = min_idx_reg;
        min_val_2_next = min_val_2_reg;
        min_valid_next = min_valid_reg;
        if (bus.round_clear && state_reg != RELEASE) begin
            min_val_next   = '1;
            min_idx_next   = '0;
            min_val_2_next = '0;
            min_valid_next = 1'b0;
        end
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            if (cap_en[i] && (!min_valid_next || val_1_in[i] < min_val_next ||
                              (val_1_in[i] == min_val_next && ADDR_W'(i) < min_idx_next))) begin
                min_val_next   = val_1_in[i];
                min_idx_next   = ADDR_W'(i);
                min_val_2_next = val_2_in[i];
                min_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_val_reg   <= '1;
            min_idx_reg   <= '0;
            min_val_2_reg <= '0;
            min_valid_reg <= 1'b0;
        end else begin
            min_val_reg   <= min_val_next;
            min_idx_reg   <= min_idx_next;
            min_val_2_reg <= min_val_2_next;
            min_valid_reg <= min_valid_next;
        end
    end

    assign bus.min_val   = min_val_reg;
    assign bus.min_idx   = min_idx_reg;
    assign bus.min_val_2 = min_val_2_reg;
`else
    assign bus.min_val   = '0;
    assign bus.min_idx   = '0;
    assign bus.min_val_2 = '0;
`endif
endmodule

// File: doc/result_collector.md
# result_collector

Parametrised gather hub between one parent core and NUM_CHILDREN child cores in the multicore cluster. It releases child resets one at a time, then captures each child's (val_1, val_2) result pair on the rising edge of that child's done flag. It exposes a registered random-read port and an all-done indication to the parent, and supports repeated rounds via a clear pulse. It replaces the parent's combinational child-select mux and flag-AND with stateful, round-based capture.

## Interface
- NUM_CHILDREN, 5: child cores served; 1..16.
- DATA_W, 32: width of each result word.
- Clk  in  1  sole clock, rising edge.
- Reset  in  1  reset, asynchronous assert, active-low.
- child_flag  in  NUM_CHILDREN  per-child done level; bit i belongs to child i.
- child_val_1  in  NUM_CHILDREN*DATA_W  packed; child i occupies [i*DATA_W +: DATA_W].
- child_val_2  in  NUM_CHILDREN*DATA_W  same packing as child_val_1.
- child_reset  out  NUM_CHILDREN  active-high reset to each child core.
- round_clear  in  1  single-cycle pulse; starts a new round.
- rd_addr  in  ADDR_W  child index to read; ADDR_W = max(1, clog2(NUM_CHILDREN)).
- rd_val_1, rd_val_2  out  DATA_W  captured pair for rd_addr.
- captured  out  NUM_CHILDREN  per-child captured mask for the current round.
- all_done  out  1  high when every child is captured.
- min_val  out  DATA_W  unsigned minimum of captured val_1 values; see Configuration.
- min_idx  out  ADDR_W  child index holding min_val.
- min_val_2  out  DATA_W  val_2 of that child.

## Operation
- FSM states: RELEASE, COLLECT, DONE.
- Reset asserted, at any time:
  - All state clears asynchronously and the FSM returns to RELEASE.
  - child_reset = all ones; captured = 0; all_done = 0; rd_val_* = 0; stored pairs = 0; flag history = 0.
- RELEASE:
  - After Reset deasserts, child i's reset drops at edge i+2 (edge 1 = first edge with Reset high). This gives one child per cycle, with a two-flop release for child 0.
  - When the last child is released, the FSM moves to COLLECT on the same edge.
  - Flags are ignored in RELEASE.
- COLLECT:
  - Capture of child i is triggered by child_flag[i] high this cycle and low the previous cycle (registered history).
  - The trigger is honoured only if captured[i] = 0. The first result per round wins; later edges are ignored.
  - On capture, val_1[i] and val_2[i] are stored and captured[i] is set.
  - Any number of children may capture in the same cycle.
- DONE:
  - Entered on the edge where captured becomes all ones. all_done rises on that same edge.
  - No further captures occur while in DONE.
- round_clear, in COLLECT or DONE:
  - Next edge: captured = 0, all_done = 0, min state reset, FSM to COLLECT.
  - Stored pairs are retained until overwritten.
  - A rising flag in the same cycle as round_clear is captured into the new round.
- round_clear in RELEASE is ignored.
- Read port:
  - rd_val_* is registered from rd_addr.
  - rd_addr >= NUM_CHILDREN returns 0.
  - A read of a child captured on the same edge returns the new value.

## Timing
- Capture latency: flag rising edge sampled at edge k → captured[i], stored data, and all_done (if last) are visible after edge k.
- Read latency is 1 cycle: rd_addr at edge k → rd_val_* after edge k.
- child_reset release completes NUM_CHILDREN+1 edges after Reset deasserts.
- No combinational path from any input to any output.

## Configuration
- COLLECTOR_MIN_REDUCE_EN defined:
  - Running unsigned minimum over captured val_1 values, updated on the capture edge.
  - Ties, including same-cycle captures, resolve to the lower index.
  - min_val resets to all ones; min_idx and min_val_2 reset to 0.
  - round_clear restores these reset values.
- COLLECTOR_MIN_REDUCE_EN undefined:
  - No comparator logic is built.
  - min_val, min_idx, and min_val_2 are tied to 0; the ports remain so the interface is stable.

## Structure
- Package collector_pkg holds:
  - the FSM state enum (RELEASE, COLLECT, DONE);
  - an addr_width(n) function returning max(1, clog2(n));
  - the DATA_W default constant.
- Sub-module reset_stagger holds the child_reset shift/release sequencer.
  - Inputs: Clk, Reset.
  - Outputs: child_reset, release_done.
  - Parameter: NUM_CHILDREN.
- The top level holds the FSM, capture registers, read port, and min reduction.

## Test plan
- Release: deassert Reset, NUM_CHILDREN=5 → child_reset steps 11111→11110→11100→11000→10000→00000 on edges 2..6; FSM enters COLLECT on edge 6.
- Capture: raise flags of children 3, 0, 4, 1, 2 on separate cycles with val_1 = 40, 10, 50, 20, 30 → captured fills bit-by-bit; all_done rises on the edge capturing child 2; rd_addr=3 returns 40 one cycle later.
- Simultaneous capture and duplicate edge: all five flags rise in one cycle → captured = 11111 and all_done after a single edge. Then drop child 0's flag and re-raise it with a new value → stored value is unchanged.
- Clear overlap: pulse round_clear in DONE while child 2's flag rises in the same cycle → captured = 00100 and all_done = 0 next edge. rd_addr=7 returns 0.
- Min reduction (macro on): captures of val_1 = 9, 5, 5, 7 for children 0..3 with child 1 and child 2 in the same cycle → min_val = 5, min_idx = 1, min_val_2 = child 1's val_2. With the macro off, all min_* outputs read 0.
- Reset mid-round: assert Reset after 3 captures → outputs clear immediately with no clock; release and collection restart from RELEASE.
